// File: rtl/ddr_tx_serializer.sv
// rtl/ddr_tx_serializer.sv - parallel-to-DDR serializer feeding a downstream ODDR primitive
//
// Purpose:
//   Accepts WIDTH-bit words over a valid/ready handshake into a single holding
//   register and shifts each word out two bits per clock on d1 (rising
//   half-cycle) and d2 (falling half-cycle). Back-to-back words are reloaded
//   from the holding register without an idle beat; when the shifter finishes
//   a word with nothing pending it returns to idle and pulses underrun.
//
// Parameters:
//   WIDTH    - parallel word width, even and >= 4
//   IDLE_VAL - level driven on d1/d2 while no word is being shifted
//
// Ports:
//   clk      in   sole clock, all state updates on the rising edge
//   rst      in   synchronous active-high reset
//   s_data   in   [WIDTH-1:0] word to transmit
//   s_valid  in   s_data is valid
//   s_ready  out  holding register is empty (registered, independent of s_valid)
//   d1       out  registered bit for the ODDR rising half-cycle
//   d2       out  registered bit for the ODDR falling half-cycle
//   busy     out  high while a word is being shifted out
//   underrun out  one-cycle pulse when shifting stops with no word pending
//
// Configuration:
//   DDR_TX_SERIALIZER_MSB_FIRST_EN - when defined, beat k drives
//   d1 = bit WIDTH-1-2k and d2 = bit WIDTH-2-2k; otherwise beat k drives
//   d1 = bit 2k and d2 = bit 2k+1.

module ddr_tx_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             d1,
    output logic             d2,
    output logic             busy,
    output logic             underrun
);

    localparam int BEATS = WIDTH / 2;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_valid;
    // Bits of the current word not yet placed on d1/d2.
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_beat;
    logic             r_d1;
    logic             r_d2;
    logic             r_busy;
    logic             r_underrun;
    logic             r_s_ready;

    logic             w_accept;
    logic             w_last_beat;
    logic             w_load;
    logic             w_stop;
    logic             w_hold_d1;
    logic             w_hold_d2;
    logic [WIDTH-1:0] w_hold_rest;
    logic             w_shift_d1;
    logic             w_shift_d2;
    logic [WIDTH-1:0] w_shift_rest;

    assign w_accept    = s_valid && r_s_ready;
    assign w_last_beat = (r_state == ST_SHIFT) && (r_beat == LAST_BEAT);
    // The shifter takes the held word either from idle or seamlessly at the
    // end of the last beat of the previous word.
    assign w_load      = r_hold_valid && ((r_state == ST_IDLE) || w_last_beat);
    assign w_stop      = w_last_beat && !r_hold_valid;

    // Beat 0 bits go straight from hold onto d1/d2 at the load edge, so the
    // shifter only keeps what remains after each presented pair.
`ifdef DDR_TX_SERIALIZER_MSB_FIRST_EN
    assign w_hold_d1    = r_hold[WIDTH-1];
    assign w_hold_d2    = r_hold[WIDTH-2];
    assign w_hold_rest  = r_hold << 2;
    assign w_shift_d1   = r_shift[WIDTH-1];
    assign w_shift_d2   = r_shift[WIDTH-2];
    assign w_shift_rest = r_shift << 2;
`else
    assign w_hold_d1    = r_hold[0];
    assign w_hold_d2    = r_hold[1];
    assign w_hold_rest  = r_hold >> 2;
    assign w_shift_d1   = r_shift[0];
    assign w_shift_d2   = r_shift[1];
    assign w_shift_rest = r_shift >> 2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_beat       <= '0;
            r_d1         <= IDLE_VAL;
            r_d2         <= IDLE_VAL;
            r_busy       <= 1'b0;
            r_underrun   <= 1'b0;
            r_s_ready    <= 1'b0;
        end else begin
            r_underrun <= 1'b0;

            if (w_load) begin
                r_state <= ST_SHIFT;
                r_busy  <= 1'b1;
                r_beat  <= '0;
                r_shift <= w_hold_rest;
                r_d1    <= w_hold_d1;
                r_d2    <= w_hold_d2;
            end else if (w_stop) begin
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
                r_beat     <= '0;
                r_d1       <= IDLE_VAL;
                r_d2       <= IDLE_VAL;
                r_underrun <= 1'b1;
            end else if (r_state == ST_SHIFT) begin
                r_beat  <= r_beat + BW'(1);
                r_shift <= w_shift_rest;
                r_d1    <= w_shift_d1;
                r_d2    <= w_shift_d2;
            end

            // s_ready is low whenever hold is full, so a drain and an accept
            // can never share an edge; s_ready reopens the cycle after a drain.
            if (w_load) begin
                r_hold_valid <= 1'b0;
                r_s_ready    <= 1'b1;
            end else if (w_accept) begin
                r_hold       <= s_data;
                r_hold_valid <= 1'b1;
                r_s_ready    <= 1'b0;
            end else begin
                // Also reopens the handshake on the first edge after reset.
                r_s_ready <= !r_hold_valid;
            end
        end
    end

    assign s_ready  = r_s_ready;
    assign d1       = r_d1;
    assign d2       = r_d2;
    assign busy     = r_busy;
    assign underrun = r_underrun;

endmodule
